// File: rtl/pbkdf2_iter_ctrl.sv
// PBKDF2-HMAC-SHA256 iteration controller: drives the shared HMAC core and XOR-folds U1..Uc into T.
// Optional macro PBKDF2_PROGRESS_EN adds the iter_done_o progress counter output.
module pbkdf2_iter_ctrl #(
    parameter int ITER_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              v_i,
    output logic              r_o,
    input  logic [439:0]      password_i,
    input  logic [479:0]      salt_i,
    input  logic [3:0]        salt_len_i,
    input  logic [31:0]       blk_idx_i,
    input  logic [ITER_W-1:0] iter_i,
    output logic [255:0]      dk_o,
    output logic              v_o,
    input  logic              r_i,
`ifdef PBKDF2_PROGRESS_EN
    output logic [ITER_W-1:0] iter_done_o,
`endif
    output logic [439:0]      hmac_key_o,
    output logic [511:0]      hmac_msg_o,
    output logic [4:0]        hmac_msg_len_o,
    output logic              hmac_v_o,
    input  logic              hmac_r_i,
    input  logic [255:0]      hmac_prf_i,
    input  logic              hmac_v_i,
    output logic              hmac_r_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [439:0]        key_q;
    logic [511:0]        msg_q;
    logic [4:0]          len_q;
    logic [255:0]        acc_q;
    logic [255:0]        dk_q;
    logic [ITER_W-1:0]   rem_q;
    logic                first_q;
    logic                accept;
    logic                resp_hs;
    logic                last_iter;
    logic [255:0]        acc_nxt;
    logic [511:0]        first_msg;
    logic [8:0]          idx_shamt;
    logic [ITER_W-1:0]   iter_eff;
`ifdef PBKDF2_PROGRESS_EN
    logic [ITER_W-1:0]   done_cnt_q;
`endif

    // First message: salt words followed immediately by the big-endian block index.
    assign idx_shamt = {salt_len_i, 5'b0};
    assign first_msg = {salt_i, 32'b0} | ({blk_idx_i, 480'b0} >> idx_shamt);
    assign iter_eff  = (iter_i == '0) ? ITER_W'(1) : iter_i;
    assign last_iter = (rem_q == ITER_W'(1));
    assign acc_nxt   = first_q ? hmac_prf_i : (acc_q ^ hmac_prf_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        r_o       = 1'b0;
        v_o       = 1'b0;
        hmac_v_o  = 1'b0;
        hmac_r_o  = 1'b0;
        accept    = 1'b0;
        resp_hs   = 1'b0;
        case (state)
            S_IDLE: begin
                r_o = 1'b1;
                if (v_i) begin
                    accept    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                hmac_v_o = 1'b1;
                if (hmac_r_i) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                hmac_r_o = 1'b1;
                if (hmac_v_i) begin
                    resp_hs   = 1'b1;
                    state_nxt = last_iter ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                v_o = 1'b1;
                if (r_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Message/len are registered so the core sees stable values for the whole ISSUE phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q   <= '0;
            msg_q   <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            dk_q    <= '0;
            rem_q   <= '0;
            first_q <= 1'b0;
        end else if (accept) begin
            key_q   <= password_i;
            msg_q   <= first_msg;
            len_q   <= {1'b0, salt_len_i} + 5'd1;
            rem_q   <= iter_eff;
            first_q <= 1'b1;
        end else if (resp_hs) begin
            msg_q   <= {hmac_prf_i, 256'b0};
            len_q   <= 5'd8;
            acc_q   <= acc_nxt;
            rem_q   <= rem_q - ITER_W'(1);
            first_q <= 1'b0;
            if (last_iter) begin
                dk_q <= acc_nxt;
            end
        end
    end

`ifdef PBKDF2_PROGRESS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || accept) begin
            done_cnt_q <= '0;
        end else if (resp_hs) begin
            done_cnt_q <= done_cnt_q + ITER_W'(1);
        end
    end

    assign iter_done_o = done_cnt_q;
`endif

    assign dk_o           = dk_q;
    assign hmac_key_o     = key_q;
    assign hmac_msg_o     = msg_q;
    assign hmac_msg_len_o = len_q;

endmodule

// File: tb/tb_pbkdf2_iter_ctrl.sv
// Directed bench for pbkdf2_iter_ctrl with a behavioural HMAC-SHA256 core of programmable latency.
module tb_pbkdf2_iter_ctrl;
    localparam int ITER_W = 32;

    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] DK_C1    = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
    localparam logic [255:0] DK_C2    = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
    localparam logic [255:0] DK_C4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;
    localparam logic [439:0] PW       = {64'h70617373776f7264, 376'b0};
    localparam logic [479:0] SALT     = {32'h73616c74, 448'b0};

    logic              clk = 1'b0;
    logic              rst;
    logic              v_i, r_o, v_o, r_i;
    logic [439:0]      password_i;
    logic [479:0]      salt_i;
    logic [3:0]        salt_len_i;
    logic [31:0]       blk_idx_i;
    logic [ITER_W-1:0] iter_i;
    logic [255:0]      dk_o;
    logic [439:0]      hmac_key_o;
    logic [511:0]      hmac_msg_o;
    logic [4:0]        hmac_msg_len_o;
    logic              hmac_v_o, hmac_r_i, hmac_v_i, hmac_r_o;
    logic [255:0]      hmac_prf_i;
`ifdef PBKDF2_PROGRESS_EN
    logic [ITER_W-1:0] iter_done_o;
`endif

    int checks = 0;
    int failures = 0;
    int issue_lat = 0;
    int resp_lat = 0;
    int rsp_st = 0;
    int rsp_cnt = 0;
    int txn_cnt = 0;
    logic [4:0]   first_len, last_len;
    logic [511:0] first_msg;

    always #5 clk = ~clk;

    pbkdf2_iter_ctrl #(.ITER_W(ITER_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .v_i            (v_i),
        .r_o            (r_o),
        .password_i     (password_i),
        .salt_i         (salt_i),
        .salt_len_i     (salt_len_i),
        .blk_idx_i      (blk_idx_i),
        .iter_i         (iter_i),
        .dk_o           (dk_o),
        .v_o            (v_o),
        .r_i            (r_i),
`ifdef PBKDF2_PROGRESS_EN
        .iter_done_o    (iter_done_o),
`endif
        .hmac_key_o     (hmac_key_o),
        .hmac_msg_o     (hmac_msg_o),
        .hmac_msg_len_o (hmac_msg_len_o),
        .hmac_v_o       (hmac_v_o),
        .hmac_r_i       (hmac_r_i),
        .hmac_prf_i     (hmac_prf_i),
        .hmac_v_i       (hmac_v_i),
        .hmac_r_o       (hmac_r_o)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // SHA-256 of up to 183 bytes held left-aligned (and zero beyond nbytes) in d.
    function automatic logic [255:0] sha256(input logic [1535:0] d, input int nbytes);
        logic [1535:0] m;
        logic [31:0]   h [8];
        logic [31:0]   w [64];
        logic [31:0]   a, b, c, dd, e, f, g, hh, t1, t2;
        int            nb;
        m = d;
        m[1535 - 8 * nbytes -: 8] = 8'h80;
        nb = (nbytes + 72) / 64;
        m[1535 - 512 * nb + 64 -: 64] = 64'(8 * nbytes);
        h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int blk = 0; blk < nb; blk++) begin
            for (int t = 0; t < 16; t++) w[t] = m[1535 - 512 * blk - 32 * t -: 32];
            for (int t = 16; t < 64; t++)
                w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
                     + w[t-7] + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
            a = h[0]; b = h[1]; c = h[2]; dd = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[t] + w[t];
                t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = dd + t1; dd = c; c = b; b = a; a = t1 + t2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += dd; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    function automatic logic [255:0] hmac_model(input logic [439:0] key, input logic [511:0] msg,
                                                input logic [4:0] len);
        logic [511:0] kblk, mm;
        logic [255:0] inner;
        kblk  = {key, 72'b0};
        mm    = msg & ~({512{1'b1}} >> (32 * int'(len)));
        inner = sha256({kblk ^ {64{8'h36}}, mm, 512'b0}, 64 + 4 * int'(len));
        return sha256({kblk ^ {64{8'h5c}}, inner, 768'b0}, 96);
    endfunction

    // Behavioural HMAC core: ready after issue_lat idle cycles, response after resp_lat cycles.
    always @(posedge clk) begin
        if (rst) begin
            hmac_r_i <= 1'b0;
            hmac_v_i <= 1'b0;
            rsp_st   <= 0;
            rsp_cnt  <= 0;
        end else begin
            case (rsp_st)
                0: begin
                    if (hmac_v_o && hmac_r_i) begin
                        hmac_prf_i <= hmac_model(hmac_key_o, hmac_msg_o, hmac_msg_len_o);
                        hmac_r_i   <= 1'b0;
                        rsp_cnt    <= 0;
                        rsp_st     <= 1;
                        txn_cnt    <= txn_cnt + 1;
                        last_len   <= hmac_msg_len_o;
                        if (txn_cnt == 0) begin
                            first_len <= hmac_msg_len_o;
                            first_msg <= hmac_msg_o;
                        end
                    end else if (!hmac_r_i) begin
                        if (rsp_cnt >= issue_lat) hmac_r_i <= 1'b1;
                        else rsp_cnt <= rsp_cnt + 1;
                    end
                end
                1: begin
                    if (rsp_cnt >= resp_lat) begin
                        hmac_v_i <= 1'b1;
                        rsp_st   <= 2;
                    end else begin
                        rsp_cnt <= rsp_cnt + 1;
                    end
                end
                default: begin
                    if (hmac_r_o) begin
                        hmac_v_i <= 1'b0;
                        rsp_cnt  <= 0;
                        rsp_st   <= 0;
                    end
                end
            endcase
        end
        if (v_i && r_o) txn_cnt <= 0;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [479:0] s, input logic [3:0] sl, input logic [31:0] bi,
                             input logic [ITER_W-1:0] c);
        @(negedge clk);
        password_i = PW;
        salt_i     = s;
        salt_len_i = sl;
        blk_idx_i  = bi;
        iter_i     = c;
        v_i        = 1'b1;
        @(posedge clk);
        #1 v_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (!v_o && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 512'(v_o), 512'(1));
    endtask

    task automatic retire();
        @(negedge clk);
        r_i = 1'b1;
        @(posedge clk);
        #1 r_i = 1'b0;
    endtask

    initial begin
        logic [479:0] salt15;
        logic [255:0] dk_hold;
        int           n;
        rst = 1'b1; v_i = 1'b0; r_i = 1'b0;
        password_i = '0; salt_i = '0; salt_len_i = '0; blk_idx_i = '0; iter_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_r_o", 512'(r_o), 512'(1));
        check("rst_v_o", 512'(v_o), 512'(0));
        check("rst_dk", 512'(dk_o), 512'(0));
        check("rst_hmac_v", 512'(hmac_v_o), 512'(0));
        check("rst_hmac_r", 512'(hmac_r_o), 512'(0));
        check("rst_key", 512'(hmac_key_o), 512'(0));
        check("rst_msg", hmac_msg_o, 512'(0));
        check("rst_len", 512'(hmac_msg_len_o), 512'(0));
`ifdef PBKDF2_PROGRESS_EN
        check("rst_iter_done", 512'(iter_done_o), 512'(0));
`endif

        // Case 1: c=1
        issue_lat = 2; resp_lat = 3;
        start_req(SALT, 4'd1, 32'd1, 32'd1);
        check("c1_accept_r_o", 512'(r_o), 512'(0));
        wait_done("c1_timeout", 500);
        check("c1_dk", 512'(dk_o), 512'(DK_C1));
        check("c1_txn", 512'(txn_cnt), 512'(1));
        check("c1_first_len", 512'(first_len), 512'(2));
        check("c1_first_msg", first_msg, {32'h73616c74, 32'h00000001, 448'b0});
        retire();

        // Case 2: c=2
        issue_lat = $urandom_range(0, 5); resp_lat = $urandom_range(0, 5);
        start_req(SALT, 4'd1, 32'd1, 32'd2);
        wait_done("c2_timeout", 500);
        check("c2_dk", 512'(dk_o), 512'(DK_C2));
        check("c2_txn", 512'(txn_cnt), 512'(2));
        check("c2_last_len", 512'(last_len), 512'(8));
        retire();

        // Case 3: c=4096
        issue_lat = 0; resp_lat = 0;
        start_req(SALT, 4'd1, 32'd1, 32'd4096);
        wait_done("c3_timeout", 40000);
        check("c3_dk", 512'(dk_o), 512'(DK_C4096));
        check("c3_txn", 512'(txn_cnt), 512'(4096));
`ifdef PBKDF2_PROGRESS_EN
        check("c3_iter_done", 512'(iter_done_o), 512'(4096));
`endif
        retire();

        // Case 4: c=0 behaves as c=1; then salt_len=15
        issue_lat = $urandom_range(0, 5); resp_lat = $urandom_range(0, 5);
        start_req(SALT, 4'd1, 32'd1, 32'd0);
        wait_done("c4_zero_timeout", 500);
        check("c4_zero_dk", 512'(dk_o), 512'(DK_C1));
        check("c4_zero_txn", 512'(txn_cnt), 512'(1));
        retire();
        salt15 = {15{32'h5a5ac3c3}};
        start_req(salt15, 4'd15, 32'h00000007, 32'd1);
        wait_done("c4_s15_timeout", 500);
        check("c4_s15_len", 512'(first_len), 512'(16));
        check("c4_s15_word15", 512'(first_msg[31:0]), 512'(32'h00000007));
        check("c4_s15_dk", 512'(dk_o), 512'(hmac_model(PW, {salt15, 32'h00000007}, 5'd16)));
        retire();

        // Case 5: back-pressure in DONE, then retire and re-request together
        start_req(SALT, 4'd1, 32'd1, 32'd1);
        wait_done("c5_timeout", 500);
        dk_hold = dk_o;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            v_i = k[0];
            check("c5_hold_v_o", 512'(v_o), 512'(1));
            check("c5_hold_dk", 512'(dk_o), 512'(DK_C1));
        end
        check("c5_dk_stable", 512'(dk_o), 512'(dk_hold));
        check("c5_no_accept_txn", 512'(txn_cnt), 512'(1));
        @(negedge clk);
        iter_i = 32'd2;
        r_i = 1'b1;
        v_i = 1'b1;
        @(posedge clk);
        #1 r_i = 1'b0;
        @(negedge clk);
        check("c5_idle_r_o", 512'(r_o), 512'(1));
        check("c5_idle_v_o", 512'(v_o), 512'(0));
        @(posedge clk);
        #1 v_i = 1'b0;
        @(negedge clk);
        check("c5_accepted_r_o", 512'(r_o), 512'(0));
        check("c5_issue", 512'(hmac_v_o), 512'(1));
        wait_done("c5b_timeout", 500);
        check("c5b_dk", 512'(dk_o), 512'(DK_C2));
        retire();

        // Case 6: reset while waiting on the core
        issue_lat = 1; resp_lat = 4;
        start_req(SALT, 4'd1, 32'd1, 32'd100);
        n = 0;
        while (!hmac_r_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("c6_reach_wait", 512'(hmac_r_o), 512'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("c6_r_o", 512'(r_o), 512'(1));
        check("c6_v_o", 512'(v_o), 512'(0));
        check("c6_dk", 512'(dk_o), 512'(0));
        check("c6_hmac_r", 512'(hmac_r_o), 512'(0));
`ifdef PBKDF2_PROGRESS_EN
        check("c6_iter_done", 512'(iter_done_o), 512'(0));
`endif
        start_req(SALT, 4'd1, 32'd1, 32'd1);
        wait_done("c6b_timeout", 500);
        check("c6b_dk", 512'(dk_o), 512'(DK_C1));
        check("c6b_txn", 512'(txn_cnt), 512'(1));
        retire();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
